// File: rtl/usb3_ep_out_dbuf_pkg.sv
// Shared types and constants for the double-buffered OUT endpoint store.
package usb3_ep_out_dbuf_pkg;

  // Endpoint mode encodings reported on endp_mode
  localparam logic [1:0] EP_MODE_CTRL  = 2'd0;
  localparam logic [1:0] EP_MODE_ISOCH = 2'd1;
  localparam logic [1:0] EP_MODE_BULK  = 2'd2;
  localparam logic [1:0] EP_MODE_INTR  = 2'd3;

  // Occupancy of one packet bank
  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  // Data toggle advances modulo 4
  function automatic logic [1:0] toggle_next(input logic [1:0] cur);
    return cur + 2'd1;
  endfunction

endpackage

// File: rtl/usb3_ep_out_dbuf_if.sv
// Link-side write/commit and external-side read/arm handshake bundle.
interface usb3_ep_out_dbuf_if #(
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 11
);
  logic [ADDR_W-1:0] buf_in_addr;
  logic [31:0]       buf_in_data;
  logic              buf_in_wren;
  logic              buf_in_ready;
  logic              buf_in_commit;
  logic [LEN_W-1:0]  buf_in_commit_len;
  logic              buf_in_commit_ack;
  logic [ADDR_W-1:0] ext_buf_out_addr;
  logic [31:0]       ext_buf_out_q;
  logic [LEN_W-1:0]  ext_buf_out_len;
  logic              ext_buf_out_hasdata;
  logic              ext_buf_out_arm;
  logic              ext_buf_out_arm_ack;

  // Producer of writes/commits and consumer of reads/arms
  modport master (
    output buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
    output ext_buf_out_addr, ext_buf_out_arm,
    input  buf_in_ready, buf_in_commit_ack,
    input  ext_buf_out_q, ext_buf_out_len, ext_buf_out_hasdata, ext_buf_out_arm_ack
  );

  // The buffer itself
  modport slave (
    input  buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
    input  ext_buf_out_addr, ext_buf_out_arm,
    output buf_in_ready, buf_in_commit_ack,
    output ext_buf_out_q, ext_buf_out_len, ext_buf_out_hasdata, ext_buf_out_arm_ack
  );
endinterface

// File: rtl/usb3_ep_out_dbuf_ram.sv
// Simple dual-port RAM holding both banks; bank select is the address MSB.
module usb3_ep_ram #(
  parameter int ADDR_W = 9
) (
  input  logic            local_clk,
  input  logic            reset,
  input  logic            we,
  input  logic [ADDR_W:0] waddr,
  input  logic [31:0]     wdata,
  input  logic [ADDR_W:0] raddr,
  output logic [31:0]     q
);
  localparam int DEPTH = 2 ** (ADDR_W + 1);

  logic [31:0] mem_r [DEPTH];
  logic [31:0] q_r;

  // Write port: storage array carries no reset so it maps onto block RAM
  always_ff @(posedge local_clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port, cleared by reset so the output starts at zero
  always_ff @(posedge local_clk) begin
    if (reset) begin
      q_r <= 32'd0;
    end else begin
      q_r <= mem_r[raddr];
    end
  end

  assign q = q_r;
endmodule

// File: rtl/usb3_ep_out_dbuf.sv
// Double-buffered OUT endpoint store: link fills banks, external side drains
// them in commit order; also owns the endpoint data toggle.
module usb3_ep_out_dbuf
  import usb3_ep_out_dbuf_pkg::*;
#(
  parameter int         ADDR_W  = 9,
  parameter int         LEN_W   = 11,
  parameter logic [1:0] EP_MODE = EP_MODE_BULK
) (
  input  logic                local_clk,
  input  logic                reset,
  usb3_ep_out_dbuf_if.slave   bus,
  input  logic                data_toggle_act,
  output logic [1:0]          data_toggle,
  output logic [1:0]          endp_mode
);

  bank_state_e      bank_r      [2];
  bank_state_e      bank_next_s [2];
  logic [LEN_W-1:0] len_r       [2];
  logic             wr_sel_r;
  logic             rd_sel_r;
  logic             commit_prev_r;
  logic             arm_prev_r;
  logic             commit_take_s;
  logic             arm_take_s;
  logic             wr_en_s;
  logic             ready_r;
  logic             hasdata_r;
  logic [LEN_W-1:0] len_out_r;
  logic             commit_ack_r;
  logic             arm_ack_r;
  logic [1:0]       toggle_r;
  logic [31:0]      ram_q_s;

  // Edge qualification and next bank occupancy; commit and arm can never
  // hit the same bank since one needs it EMPTY and the other FULL
  always_comb begin
    commit_take_s = 1'b0;
    arm_take_s    = 1'b0;
    bank_next_s   = bank_r;
    if (bus.buf_in_commit && !commit_prev_r && (bank_r[wr_sel_r] == BANK_EMPTY)) begin
      commit_take_s = 1'b1;
    end else begin
      commit_take_s = 1'b0;
    end
    if (bus.ext_buf_out_arm && !arm_prev_r && (bank_r[rd_sel_r] == BANK_FULL)) begin
      arm_take_s = 1'b1;
    end else begin
      arm_take_s = 1'b0;
    end
    if (commit_take_s) begin
      bank_next_s[wr_sel_r] = BANK_FULL;
    end else begin
      bank_next_s[wr_sel_r] = bank_r[wr_sel_r];
    end
    if (arm_take_s) begin
      bank_next_s[rd_sel_r] = BANK_EMPTY;
    end else begin
      bank_next_s[rd_sel_r] = bank_next_s[rd_sel_r];
    end
  end

  // Writes also check the live bank state: ready lags a commit by one
  // cycle and must not let a stale high land data in a full bank
  assign wr_en_s = bus.buf_in_wren && ready_r && (bank_r[wr_sel_r] == BANK_EMPTY);

  // Bank state, selectors, committed lengths and edge-detector history
  always_ff @(posedge local_clk) begin
    if (reset) begin
      bank_r[0]     <= BANK_EMPTY;
      bank_r[1]     <= BANK_EMPTY;
      len_r[0]      <= '0;
      len_r[1]      <= '0;
      wr_sel_r      <= 1'b0;
      rd_sel_r      <= 1'b0;
      commit_prev_r <= 1'b0;
      arm_prev_r    <= 1'b0;
    end else begin
      bank_r        <= bank_next_s;
      commit_prev_r <= bus.buf_in_commit;
      arm_prev_r    <= bus.ext_buf_out_arm;
      if (commit_take_s) begin
        len_r[wr_sel_r] <= bus.buf_in_commit_len;
        wr_sel_r        <= ~wr_sel_r;
      end
      if (arm_take_s) begin
        rd_sel_r <= ~rd_sel_r;
      end
    end
  end

  // Registered status outputs and single-cycle acknowledge pulses
  always_ff @(posedge local_clk) begin
    if (reset) begin
      ready_r      <= 1'b0;
      hasdata_r    <= 1'b0;
      len_out_r    <= '0;
      commit_ack_r <= 1'b0;
      arm_ack_r    <= 1'b0;
    end else begin
      ready_r      <= (bank_r[wr_sel_r] == BANK_EMPTY);
      hasdata_r    <= (bank_r[rd_sel_r] == BANK_FULL);
      len_out_r    <= len_r[rd_sel_r];
      commit_ack_r <= commit_take_s;
      arm_ack_r    <= arm_take_s;
    end
  end

  // Data toggle counter, independent of bank traffic
  always_ff @(posedge local_clk) begin
    if (reset) begin
      toggle_r <= 2'd0;
    end else if (data_toggle_act) begin
      toggle_r <= toggle_next(toggle_r);
    end
  end

  usb3_ep_ram #(.ADDR_W(ADDR_W)) u_ram (
    .local_clk (local_clk),
    .reset     (reset),
    .we        (wr_en_s),
    .waddr     ({wr_sel_r, bus.buf_in_addr}),
    .wdata     (bus.buf_in_data),
    .raddr     ({rd_sel_r, bus.ext_buf_out_addr}),
    .q         (ram_q_s)
  );

  assign bus.buf_in_ready        = ready_r;
  assign bus.buf_in_commit_ack   = commit_ack_r;
  assign bus.ext_buf_out_q       = ram_q_s;
  assign bus.ext_buf_out_len     = len_out_r;
  assign bus.ext_buf_out_hasdata = hasdata_r;
  assign bus.ext_buf_out_arm_ack = arm_ack_r;
  assign data_toggle             = toggle_r;
  assign endp_mode               = EP_MODE;

endmodule

// File: tb/tb_usb3_ep_out_dbuf.sv
// Self-checking bench for usb3_ep_out_dbuf: table-driven write/read and toggle
// vectors, a read-data scoreboard, and hand sequences for bank corner cases.
module tb_usb3_ep_out_dbuf;

  logic       local_clk;
  logic       reset;
  logic       data_toggle_act;
  logic [1:0] data_toggle;
  logic [1:0] endp_mode;

  int tests_run;
  int tests_failed;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_q;
  } rw_vec_t;

  typedef struct {
    logic       act;
    logic [1:0] exp_tog;
  } tog_vec_t;

  rw_vec_t  rw_tbl  [4];
  tog_vec_t tog_tbl [7];

  usb3_ep_out_dbuf_if #(.ADDR_W(9), .LEN_W(11)) bus ();

  usb3_ep_out_dbuf #(.ADDR_W(9), .LEN_W(11), .EP_MODE(2'd2)) dut (
    .local_clk       (local_clk),
    .reset           (reset),
    .bus             (bus),
    .data_toggle_act (data_toggle_act),
    .data_toggle     (data_toggle),
    .endp_mode       (endp_mode)
  );

  initial local_clk = 1'b0;
  always #5 local_clk = ~local_clk;

  task automatic tick();
    @(posedge local_clk);
    @(negedge local_clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr_word(input logic [8:0] addr, input logic [31:0] data);
    bus.buf_in_addr = addr;
    bus.buf_in_data = data;
    bus.buf_in_wren = 1'b1;
    tick();
    bus.buf_in_wren = 1'b0;
  endtask

  // Drive a read address, predict the word, compare one cycle later
  task automatic rd_check(input string name, input logic [8:0] addr, input logic [31:0] exp);
    logic [31:0] e;
    bus.ext_buf_out_addr = addr;
    exp_q.push_back(exp);
    tick();
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      chk(name, bus.ext_buf_out_q, e);
    end
  endtask

  task automatic commit_pulse(input string name, input logic [10:0] len, input logic exp_ack);
    bus.buf_in_commit     = 1'b1;
    bus.buf_in_commit_len = len;
    tick();
    chk(name, {31'd0, bus.buf_in_commit_ack}, {31'd0, exp_ack});
    bus.buf_in_commit = 1'b0;
    tick();
  endtask

  task automatic arm_pulse(input string name, input logic exp_ack);
    bus.ext_buf_out_arm = 1'b1;
    tick();
    chk(name, {31'd0, bus.ext_buf_out_arm_ack}, {31'd0, exp_ack});
    bus.ext_buf_out_arm = 1'b0;
    tick();
  endtask

  initial begin
    int acks;
    tests_run    = 0;
    tests_failed = 0;

    rw_tbl[0] = '{addr: 9'd0, wdata: 32'hA0, exp_q: 32'hA0};
    rw_tbl[1] = '{addr: 9'd1, wdata: 32'hA1, exp_q: 32'hA1};
    rw_tbl[2] = '{addr: 9'd2, wdata: 32'hA2, exp_q: 32'hA2};
    rw_tbl[3] = '{addr: 9'd3, wdata: 32'hA3, exp_q: 32'hA3};

    tog_tbl[0] = '{act: 1'b1, exp_tog: 2'd1};
    tog_tbl[1] = '{act: 1'b0, exp_tog: 2'd1};
    tog_tbl[2] = '{act: 1'b1, exp_tog: 2'd2};
    tog_tbl[3] = '{act: 1'b1, exp_tog: 2'd3};
    tog_tbl[4] = '{act: 1'b1, exp_tog: 2'd0};
    tog_tbl[5] = '{act: 1'b0, exp_tog: 2'd0};
    tog_tbl[6] = '{act: 1'b1, exp_tog: 2'd1};

    reset                 = 1'b1;
    data_toggle_act       = 1'b0;
    bus.buf_in_addr       = 9'd0;
    bus.buf_in_data       = 32'd0;
    bus.buf_in_wren       = 1'b0;
    bus.buf_in_commit     = 1'b0;
    bus.buf_in_commit_len = 11'd0;
    bus.ext_buf_out_addr  = 9'd0;
    bus.ext_buf_out_arm   = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_hasdata", {31'd0, bus.ext_buf_out_hasdata}, 32'd0);
    chk("rst_len", {21'd0, bus.ext_buf_out_len}, 32'd0);
    chk("rst_q", bus.ext_buf_out_q, 32'd0);
    chk("rst_cack", {31'd0, bus.buf_in_commit_ack}, 32'd0);
    chk("rst_aack", {31'd0, bus.ext_buf_out_arm_ack}, 32'd0);
    chk("rst_toggle", {30'd0, data_toggle}, 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_ready", {31'd0, bus.buf_in_ready}, 32'd1);

    // 1: write A0..A3, commit 16 bytes, read back through the scoreboard
    for (int i = 0; i < 4; i++) begin
      wr_word(rw_tbl[i].addr, rw_tbl[i].wdata);
    end
    commit_pulse("t1_commit_ack", 11'd16, 1'b1);
    chk("t1_ack_clear", {31'd0, bus.buf_in_commit_ack}, 32'd0);
    chk("t1_hasdata", {31'd0, bus.ext_buf_out_hasdata}, 32'd1);
    chk("t1_len", {21'd0, bus.ext_buf_out_len}, 32'd16);
    for (int i = 0; i < 4; i++) begin
      rd_check("t1_read", rw_tbl[i].addr, rw_tbl[i].exp_q);
    end
    arm_pulse("t1_arm_ack", 1'b1);
    chk("t1_drained", {31'd0, bus.ext_buf_out_hasdata}, 32'd0);

    // 2: fill both banks, third commit refused, writes while full dropped
    wr_word(9'd0, 32'h11);
    commit_pulse("t2_commit8", 11'd8, 1'b1);
    wr_word(9'd0, 32'h22);
    commit_pulse("t2_commit12", 11'd12, 1'b1);
    chk("t2_ready_low", {31'd0, bus.buf_in_ready}, 32'd0);
    chk("t2_len8", {21'd0, bus.ext_buf_out_len}, 32'd8);
    commit_pulse("t2_commit_refused", 11'd30, 1'b0);
    chk("t2_len_kept", {21'd0, bus.ext_buf_out_len}, 32'd8);
    wr_word(9'd0, 32'hDEAD);
    rd_check("t2_read_first", 9'd0, 32'h11);
    arm_pulse("t2_arm1", 1'b1);
    chk("t2_len12", {21'd0, bus.ext_buf_out_len}, 32'd12);
    chk("t2_ready_back", {31'd0, bus.buf_in_ready}, 32'd1);
    chk("t2_hasdata_second", {31'd0, bus.ext_buf_out_hasdata}, 32'd1);
    rd_check("t2_read_second", 9'd0, 32'h22);
    arm_pulse("t2_arm2", 1'b1);
    chk("t2_empty", {31'd0, bus.ext_buf_out_hasdata}, 32'd0);
    arm_pulse("t2_arm_nodata", 1'b0);

    // 3: commit into one bank while the other is released in the same cycle
    commit_pulse("t3_commit20", 11'd20, 1'b1);
    bus.buf_in_commit     = 1'b1;
    bus.buf_in_commit_len = 11'd24;
    bus.ext_buf_out_arm   = 1'b1;
    tick();
    chk("t3_cack", {31'd0, bus.buf_in_commit_ack}, 32'd1);
    chk("t3_aack", {31'd0, bus.ext_buf_out_arm_ack}, 32'd1);
    bus.buf_in_commit   = 1'b0;
    bus.ext_buf_out_arm = 1'b0;
    tick();
    chk("t3_hasdata", {31'd0, bus.ext_buf_out_hasdata}, 32'd1);
    chk("t3_len24", {21'd0, bus.ext_buf_out_len}, 32'd24);
    chk("t3_ready", {31'd0, bus.buf_in_ready}, 32'd1);
    arm_pulse("t3_arm", 1'b1);

    // 4: zero-length packet; held commit and held arm each ack once
    acks = 0;
    bus.buf_in_commit     = 1'b1;
    bus.buf_in_commit_len = 11'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.buf_in_commit_ack) acks++;
    end
    bus.buf_in_commit = 1'b0;
    tick();
    chk("t4_commit_held_acks", acks, 32'd1);
    chk("t4_zlp_hasdata", {31'd0, bus.ext_buf_out_hasdata}, 32'd1);
    chk("t4_zlp_len", {21'd0, bus.ext_buf_out_len}, 32'd0);
    acks = 0;
    bus.ext_buf_out_arm = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.ext_buf_out_arm_ack) acks++;
    end
    bus.ext_buf_out_arm = 1'b0;
    tick();
    chk("t4_arm_held_acks", acks, 32'd1);
    chk("t4_released", {31'd0, bus.ext_buf_out_hasdata}, 32'd0);

    // 5: reset with both banks full and a nonzero toggle
    commit_pulse("t5_fill_a", 11'd4, 1'b1);
    commit_pulse("t5_fill_b", 11'd5, 1'b1);
    data_toggle_act = 1'b1;
    tick();
    data_toggle_act = 1'b0;
    chk("t5_pre_ready", {31'd0, bus.buf_in_ready}, 32'd0);
    chk("t5_pre_toggle", {30'd0, data_toggle}, 32'd1);
    reset = 1'b1;
    tick();
    chk("t5_hasdata", {31'd0, bus.ext_buf_out_hasdata}, 32'd0);
    chk("t5_toggle", {30'd0, data_toggle}, 32'd0);
    chk("t5_cack", {31'd0, bus.buf_in_commit_ack}, 32'd0);
    chk("t5_aack", {31'd0, bus.ext_buf_out_arm_ack}, 32'd0);
    reset = 1'b0;
    tick();
    chk("t5_ready", {31'd0, bus.buf_in_ready}, 32'd1);
    chk("t5_still_empty", {31'd0, bus.ext_buf_out_hasdata}, 32'd0);

    // 6: toggle sequence from the table, constant endpoint mode
    for (int i = 0; i < 7; i++) begin
      data_toggle_act = tog_tbl[i].act;
      tick();
      chk("t6_toggle", {30'd0, data_toggle}, {30'd0, tog_tbl[i].exp_tog});
    end
    data_toggle_act = 1'b0;
    chk("t6_endp_mode", {30'd0, endp_mode}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
